// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order circular buffer from rename to execute, 2 uops in / 1 uop out per cycle.
// Optional DISPATCH_CAP_SERIALIZE_EN holds issue after each capability uop until cap_complete_i.

package uop_pkg;
  typedef logic [7:0] uop_tag_t;
  localparam uop_tag_t INT_ALU  = 8'h01;
  localparam uop_tag_t CAP_JUMP = 8'h81;
  localparam uop_tag_t CAP_RET  = 8'h82;
endpackage

module dispatch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_UOPS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dispatch_valid_i,
  input  uop_pkg::uop_tag_t          dispatch_uop0_i,
  input  uop_pkg::uop_tag_t          dispatch_uop1_i,
  input  logic [1:0]                 dispatch_uop_count_i,
  input  logic [MAX_UOPS-1:0]        lane_is_capability_i,
  output logic                       dispatch_ready_o,
  input  logic                       flush_i,
  output logic                       issue_valid_o,
  output uop_pkg::uop_tag_t          issue_uop_o,
  output logic                       issue_is_capability_o,
  input  logic                       issue_ready_i,
  input  logic                       cap_complete_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [15:0]                capability_issued_count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  localparam logic [0:0] StRun     = 1'b0;
  localparam logic [0:0] StWaitCap = 1'b1;

  uop_pkg::uop_tag_t tag_mem [DEPTH];
  logic [DEPTH-1:0]  cap_mem;

  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, wptr_plus1;
  logic [OccW-1:0] occ_q, occ_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [0:0]      state_q, state_d;
  logic [1:0]      lanes;
  logic            push, pop;

  // Counts above two clamp to a full two-lane beat.
  assign lanes = (dispatch_uop_count_i > 2'd2) ? 2'd2 : dispatch_uop_count_i;

  assign dispatch_ready_o      = (occ_q <= OccW'(DEPTH - 2)) && !flush_i;
  assign issue_valid_o         = (occ_q != '0) && (state_q == StRun) && !flush_i;
  assign issue_uop_o           = tag_mem[rptr_q];
  assign issue_is_capability_o = cap_mem[rptr_q];

  assign push       = dispatch_valid_i && dispatch_ready_o;
  assign pop        = issue_valid_o && issue_ready_i;
  assign wptr_plus1 = wptr_q + PtrW'(1);

  assign occupancy_o               = occ_q;
  assign capability_issued_count_o = cnt_q;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      occ_d   = '0;
      state_d = StRun;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(lanes);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      occ_d = occ_q + OccW'(push ? lanes : 2'd0) - OccW'(pop);
      if (pop && issue_is_capability_o) cnt_d = cnt_q + 16'd1;
`ifdef DISPATCH_CAP_SERIALIZE_EN
      unique case (state_q)
        StRun:     if (pop && issue_is_capability_o) state_d = StWaitCap;
        StWaitCap: if (cap_complete_i) state_d = StRun;
        default:   state_d = StRun;
      endcase
`endif
    end
  end

`ifndef DISPATCH_CAP_SERIALIZE_EN
  logic unused_cap_complete;
  assign unused_cap_complete = cap_complete_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      state_q <= StRun;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone says which slots are live.
  always_ff @(posedge clk_i) begin
    if (push && (lanes != 2'd0)) begin
      tag_mem[wptr_q] <= dispatch_uop0_i;
      cap_mem[wptr_q] <= lane_is_capability_i[0];
    end
    if (push && (lanes == 2'd2)) begin
      tag_mem[wptr_plus1] <= dispatch_uop1_i;
      cap_mem[wptr_plus1] <= lane_is_capability_i[1];
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: scoreboard bench for dispatch_queue; expected entries are queued on push
// and compared on pop. Follows DISPATCH_CAP_SERIALIZE_EN when defined.
module tb_dispatch_queue;
  import uop_pkg::*;

  localparam int DEPTH = 8;
  localparam int OCCW  = $clog2(DEPTH + 1);

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            dispatch_valid_i;
  uop_tag_t        dispatch_uop0_i, dispatch_uop1_i;
  logic [1:0]      dispatch_uop_count_i;
  logic [1:0]      lane_is_capability_i;
  logic            dispatch_ready_o;
  logic            flush_i;
  logic            issue_valid_o;
  uop_tag_t        issue_uop_o;
  logic            issue_is_capability_o;
  logic            issue_ready_i;
  logic            cap_complete_i;
  logic [OCCW-1:0] occupancy_o;
  logic [15:0]     capability_issued_count_o;

  dispatch_queue #(.DEPTH(DEPTH), .MAX_UOPS(2)) dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .dispatch_valid_i         (dispatch_valid_i),
    .dispatch_uop0_i          (dispatch_uop0_i),
    .dispatch_uop1_i          (dispatch_uop1_i),
    .dispatch_uop_count_i     (dispatch_uop_count_i),
    .lane_is_capability_i     (lane_is_capability_i),
    .dispatch_ready_o         (dispatch_ready_o),
    .flush_i                  (flush_i),
    .issue_valid_o            (issue_valid_o),
    .issue_uop_o              (issue_uop_o),
    .issue_is_capability_o    (issue_is_capability_o),
    .issue_ready_i            (issue_ready_i),
    .cap_complete_i           (cap_complete_i),
    .occupancy_o              (occupancy_o),
    .capability_issued_count_o(capability_issued_count_o)
  );

  always #5 clk_i = ~clk_i;

  int          total, bad;
  logic [8:0]  m_q[$];   // {cap, tag}
  bit          m_wait;
  logic [15:0] m_cnt;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit rst, input bit v, input uop_tag_t u0, input uop_tag_t u1,
                       input logic [1:0] cnt, input logic [1:0] capf, input bit rdy,
                       input bit fl, input bit cc);
    rst_i                = rst;
    dispatch_valid_i     = v;
    dispatch_uop0_i      = u0;
    dispatch_uop1_i      = u1;
    dispatch_uop_count_i = cnt;
    lane_is_capability_i = capf;
    issue_ready_i        = rdy;
    flush_i              = fl;
    cap_complete_i       = cc;
    #1;
  endtask

  // Reference model: returns this cycle's expected outputs and commits the next-edge state.
  task automatic model_eval(output bit er, output bit ev, output bit ep, output logic [8:0] ee,
                            output int eo, output logic [15:0] ec);
    int lanes;
    er = (m_q.size() <= DEPTH - 2) && !flush_i;
    ev = (m_q.size() != 0) && !m_wait && !flush_i;
    ep = ev && issue_ready_i;
    ee = (m_q.size() != 0) ? m_q[0] : 9'h000;
    eo = m_q.size();
    ec = m_cnt;
    if (rst_i) begin
      m_q.delete();
      m_wait = 1'b0;
      m_cnt  = 16'h0000;
    end else if (flush_i) begin
      m_q.delete();
      m_wait = 1'b0;
    end else begin
      if (m_wait && cap_complete_i) m_wait = 1'b0;
      if (ep) begin
        void'(m_q.pop_front());
        if (ee[8]) begin
          m_cnt = m_cnt + 16'd1;
`ifdef DISPATCH_CAP_SERIALIZE_EN
          m_wait = 1'b1;
`endif
        end
      end
      if (dispatch_valid_i && er) begin
        lanes = (dispatch_uop_count_i > 2'd2) ? 2 : int'(dispatch_uop_count_i);
        if (lanes >= 1) m_q.push_back({lane_is_capability_i[0], dispatch_uop0_i});
        if (lanes == 2) m_q.push_back({lane_is_capability_i[1], dispatch_uop1_i});
      end
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 8'h00, 2'd0, 2'b00, 0, 0, 0);
    tick();
    drive(1, 0, 8'h00, 8'h00, 2'd0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++; if (dispatch_ready_o !== 1'b1) begin bad++;
        $display("FAIL reset_ready ph=%0d got=%b exp=1", k, dispatch_ready_o); end
      total++; if (issue_valid_o !== 1'b0) begin bad++;
        $display("FAIL reset_valid ph=%0d got=%b exp=0", k, issue_valid_o); end
      total++; if (occupancy_o !== '0) begin bad++;
        $display("FAIL reset_occ ph=%0d got=%0d exp=0", k, occupancy_o); end
      total++; if (capability_issued_count_o !== 16'h0000) begin bad++;
        $display("FAIL reset_cnt ph=%0d got=%0d exp=0", k, capability_issued_count_o); end
      tick();
      drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 0, 0, 0);
    end
    m_q.delete(); m_wait = 1'b0; m_cnt = 16'h0000;
  endtask

  task automatic test_basic();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) drive(0, 1, INT_ALU, CAP_JUMP, 2'd2, 2'b10, 1, 0, 0);
      else        drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (issue_valid_o !== ev) begin bad++;
        $display("FAIL basic_valid cyc=%0d got=%b exp=%b", i, issue_valid_o, ev); end
      total++; if (occupancy_o !== OCCW'(eo)) begin bad++;
        $display("FAIL basic_occ cyc=%0d got=%0d exp=%0d", i, occupancy_o, eo); end
      if (ep) begin total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
        $display("FAIL basic_pop cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, ee); end end
      if (i == 1) begin total++; if (issue_uop_o !== INT_ALU) begin bad++;
        $display("FAIL basic_first cyc=%0d got=%h exp=%h", i, issue_uop_o, INT_ALU); end end
      if (i == 2) begin total++; if ({issue_is_capability_o, issue_uop_o} !== {1'b1, CAP_JUMP}) begin bad++;
        $display("FAIL basic_second cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, {1'b1, CAP_JUMP}); end end
      if (i == 3) begin total++; if (capability_issued_count_o !== 16'd1 || occupancy_o !== '0) begin bad++;
        $display("FAIL basic_end cnt=%0d occ=%0d exp cnt=1 occ=0", capability_issued_count_o, occupancy_o); end end
    end
  endtask

  task automatic test_fill();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i < 4)       drive(0, 1, 8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i), 2'd2, 2'b00, 0, 0, 0);
      else if (i == 4) drive(0, 1, 8'hEE, 8'hEF, 2'd2, 2'b11, 0, 0, 0);
      else             drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (dispatch_ready_o !== er) begin bad++;
        $display("FAIL fill_ready cyc=%0d got=%b exp=%b", i, dispatch_ready_o, er); end
      total++; if (issue_valid_o !== ev) begin bad++;
        $display("FAIL fill_valid cyc=%0d got=%b exp=%b", i, issue_valid_o, ev); end
      total++; if (occupancy_o !== OCCW'(eo)) begin bad++;
        $display("FAIL fill_occ cyc=%0d got=%0d exp=%0d", i, occupancy_o, eo); end
      if (ep) begin total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
        $display("FAIL fill_pop cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, ee); end end
      if (i == 3) begin total++; if (dispatch_ready_o !== 1'b1) begin bad++;
        $display("FAIL fill_ready_at6 got=%b exp=1", dispatch_ready_o); end end
      if (i == 4) begin total++; if (dispatch_ready_o !== 1'b0) begin bad++;
        $display("FAIL fill_ready_at8 got=%b exp=0", dispatch_ready_o); end end
      if (i == 5) begin total++; if (occupancy_o !== OCCW'(8)) begin bad++;
        $display("FAIL fill_held_beat occ=%0d exp=8", occupancy_o); end end
    end
  endtask

  task automatic test_wrap();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec; int pops;
    pops = 0;
    for (int i = 0; i < 23; i++) begin
      tick();
      if (i < 20) drive(0, 1, 8'(8'h40 + i), 8'hFF, 2'd1, 2'b00, 1, 0, 0);
      else        drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (issue_valid_o !== ev) begin bad++;
        $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", i, issue_valid_o, ev); end
      total++; if (occupancy_o !== OCCW'(eo)) begin bad++;
        $display("FAIL wrap_occ cyc=%0d got=%0d exp=%0d", i, occupancy_o, eo); end
      if (ep) begin
        pops++;
        total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
          $display("FAIL wrap_order cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, ee); end
      end
    end
    total++; if (pops != 20) begin bad++; $display("FAIL wrap_pops got=%0d exp=20", pops); end
  endtask

  task automatic test_count3();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i < 3)       drive(0, 1, 8'(8'h60 + 2 * i), 8'(8'h61 + 2 * i), 2'd2, 2'b00, 0, 0, 0);
      else if (i == 3) drive(0, 1, 8'h70, CAP_JUMP, 2'd3, 2'b10, 0, 0, 0);
      else             drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (occupancy_o !== OCCW'(eo)) begin bad++;
        $display("FAIL cnt3_occ cyc=%0d got=%0d exp=%0d", i, occupancy_o, eo); end
      total++; if (capability_issued_count_o !== ec) begin bad++;
        $display("FAIL cnt3_capcnt cyc=%0d got=%0d exp=%0d", i, capability_issued_count_o, ec); end
      if (ep) begin total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
        $display("FAIL cnt3_pop cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, ee); end end
      if (i == 4) begin total++; if (occupancy_o !== OCCW'(8)) begin bad++;
        $display("FAIL cnt3_plus2 occ=%0d exp=8", occupancy_o); end end
    end
  endtask

  task automatic test_serial();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) drive(0, 1, CAP_RET, INT_ALU, 2'd2, 2'b01, 1, 0, 0);
      else        drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, i == 4);
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (issue_valid_o !== ev) begin bad++;
        $display("FAIL serial_valid cyc=%0d got=%b exp=%b", i, issue_valid_o, ev); end
      if (ep) begin total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
        $display("FAIL serial_pop cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, ee); end end
`ifdef DISPATCH_CAP_SERIALIZE_EN
      if (i >= 2 && i <= 4) begin total++; if (issue_valid_o !== 1'b0) begin bad++;
        $display("FAIL serial_hold cyc=%0d got=%b exp=0", i, issue_valid_o); end end
      if (i == 5) begin total++; if (issue_valid_o !== 1'b1 || issue_uop_o !== INT_ALU) begin bad++;
        $display("FAIL serial_resume got v=%b uop=%h exp v=1 uop=%h", issue_valid_o, issue_uop_o, INT_ALU); end end
`else
      if (i == 2) begin total++; if (issue_valid_o !== 1'b1 || issue_uop_o !== INT_ALU) begin bad++;
        $display("FAIL serial_b2b got v=%b uop=%h exp v=1 uop=%h", issue_valid_o, issue_uop_o, INT_ALU); end end
`endif
    end
  endtask

  task automatic test_flush();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec; logic [15:0] cnt_save;
    cnt_save = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      case (i)
        0:       drive(0, 1, CAP_RET, 8'h21, 2'd2, 2'b01, 0, 0, 0);
        1:       drive(0, 1, 8'h22, 8'h23, 2'd2, 2'b00, 0, 0, 0);
        2:       drive(0, 1, 8'h24, 8'h25, 2'd2, 2'b00, 0, 0, 0);
        3:       drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
        4:       drive(0, 1, 8'h30, 8'h31, 2'd2, 2'b00, 1, 1, 0);
        5:       drive(0, 1, 8'h50, 8'h51, 2'd2, 2'b00, 1, 0, 0);
        default: drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
      endcase
      if (i == 4) cnt_save = m_cnt;
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (dispatch_ready_o !== er) begin bad++;
        $display("FAIL flush_ready cyc=%0d got=%b exp=%b", i, dispatch_ready_o, er); end
      total++; if (issue_valid_o !== ev) begin bad++;
        $display("FAIL flush_valid cyc=%0d got=%b exp=%b", i, issue_valid_o, ev); end
      total++; if (occupancy_o !== OCCW'(eo)) begin bad++;
        $display("FAIL flush_occ cyc=%0d got=%0d exp=%0d", i, occupancy_o, eo); end
      if (ep) begin total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
        $display("FAIL flush_pop cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, ee); end end
      if (i == 4) begin total++; if (occupancy_o !== OCCW'(5)) begin bad++;
        $display("FAIL flush_pre_occ got=%0d exp=5", occupancy_o); end end
      if (i == 5) begin total++;
        if (occupancy_o !== '0 || issue_valid_o !== 1'b0 || capability_issued_count_o !== cnt_save) begin bad++;
          $display("FAIL flush_after occ=%0d v=%b cnt=%0d exp occ=0 v=0 cnt=%0d",
                   occupancy_o, issue_valid_o, capability_issued_count_o, cnt_save); end end
      if (i == 6) begin total++; if (issue_valid_o !== 1'b1 || issue_uop_o !== 8'h50) begin bad++;
        $display("FAIL flush_restart v=%b uop=%h exp v=1 uop=50", issue_valid_o, issue_uop_o); end end
    end
  endtask

  task automatic test_reset_mid();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec;
    for (int i = 0; i < 9; i++) begin
      tick();
      case (i)
        0:       drive(0, 1, CAP_JUMP, 8'h91, 2'd2, 2'b01, 0, 0, 0);
        1:       drive(0, 1, 8'h92, 8'h93, 2'd2, 2'b00, 0, 0, 0);
        2:       drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
        3:       drive(1, 0, 8'h00, 8'h00, 2'd0, 2'b00, 0, 0, 0);
        5:       drive(0, 1, 8'h94, 8'h95, 2'd2, 2'b00, 1, 0, 0);
        default: drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 1, 0, 0);
      endcase
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (issue_valid_o !== ev) begin bad++;
        $display("FAIL rstmid_valid cyc=%0d got=%b exp=%b", i, issue_valid_o, ev); end
      total++; if (occupancy_o !== OCCW'(eo)) begin bad++;
        $display("FAIL rstmid_occ cyc=%0d got=%0d exp=%0d", i, occupancy_o, eo); end
      total++; if (capability_issued_count_o !== ec) begin bad++;
        $display("FAIL rstmid_cnt cyc=%0d got=%0d exp=%0d", i, capability_issued_count_o, ec); end
      if (ep) begin total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
        $display("FAIL rstmid_pop cyc=%0d got=%h exp=%h", i, {issue_is_capability_o, issue_uop_o}, ee); end end
      if (i == 4) begin total++;
        if (occupancy_o !== '0 || capability_issued_count_o !== 16'h0000 || dispatch_ready_o !== 1'b1) begin bad++;
          $display("FAIL rstmid_after occ=%0d cnt=%0d rdy=%b exp occ=0 cnt=0 rdy=1",
                   occupancy_o, capability_issued_count_o, dispatch_ready_o); end end
    end
  endtask

  task automatic test_cnt_wrap();
    bit er, ev, ep; logic [8:0] ee; int eo; logic [15:0] ec;
    int n, pushed, cyc;
    bit push;
    n = 65536 - int'(m_cnt);
    pushed = 0;
    cyc = 0;
    while ((pushed < n || m_q.size() != 0) && cyc < 3 * n + 100) begin
      tick();
      push = (pushed < n) && (m_q.size() < 4);
      drive(0, push, 8'(8'h80 + (pushed % 64)), 8'h00, 2'd1, 2'b01, 1, 0, 1);
      model_eval(er, ev, ep, ee, eo, ec);
      total++; if (issue_valid_o !== ev) begin bad++;
        $display("FAIL wrap_cnt_valid cyc=%0d got=%b exp=%b", cyc, issue_valid_o, ev); end
      total++; if (capability_issued_count_o !== ec) begin bad++;
        $display("FAIL wrap_cnt_value cyc=%0d got=%0d exp=%0d", cyc, capability_issued_count_o, ec); end
      if (ep) begin total++; if ({issue_is_capability_o, issue_uop_o} !== ee) begin bad++;
        $display("FAIL wrap_cnt_pop cyc=%0d got=%h exp=%h", cyc, {issue_is_capability_o, issue_uop_o}, ee); end end
      if (push && er) pushed++;
      cyc++;
    end
    total++; if (pushed < n || m_q.size() != 0) begin bad++;
      $display("FAIL wrap_cnt_timeout pushed=%0d pending=%0d exp pushed=%0d pending=0", pushed, m_q.size(), n); end
    tick();
    drive(0, 0, 8'h00, 8'h00, 2'd0, 2'b00, 0, 0, 0);
    total++; if (capability_issued_count_o !== 16'h0000) begin bad++;
      $display("FAIL wrap_cnt_zero got=%h exp=0000", capability_issued_count_o); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; m_wait = 1'b0; m_cnt = 16'h0000;
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_count3();
    test_serial();
    test_flush();
    test_reset_mid();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Receiving end of the rename→dispatch interface in the Amber v0.4 core. Accepts up to two micro-op tags per cycle, with per-lane capability flags, from the rename stage. Buffers them in order in a circular queue and issues one micro-op per cycle to the execution side over a valid/ready handshake. Optionally serialises capability micro-ops behind a completion pulse, and counts issued capability micro-ops.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥ 4.
- `MAX_UOPS`, 2: lanes per dispatch beat; fixed at 2.

- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `dispatch_valid_i` input 1: rename offers a beat.
- `dispatch_uop0_i` input `uop_pkg::uop_tag_t`: lane 0 tag.
- `dispatch_uop1_i` input `uop_pkg::uop_tag_t`: lane 1 tag.
- `dispatch_uop_count_i` input 2: valid lanes in the beat (0–3; values above 2 clamp to 2).
- `lane_is_capability_i` input `MAX_UOPS`: per-lane capability flag.
- `dispatch_ready_o` output 1: queue can take a full beat.
- `flush_i` input 1: discard all queued entries.
- `issue_valid_o` output 1: head entry available.
- `issue_uop_o` output `uop_pkg::uop_tag_t`: head tag.
- `issue_is_capability_o` output 1: head capability flag.
- `issue_ready_i` input 1: execution accepts the head.
- `cap_complete_i` input 1: capability op finished (serialise mode only).
- `occupancy_o` output `$clog2(DEPTH+1)`: entries held.
- `capability_issued_count_o` output 16: issued capability uops, wrapping.

## Operation
- Storage: `DEPTH` entries of {tag, cap flag}.
- Pointers: `$clog2(DEPTH)`-bit read and write pointers, wrapping modulo `DEPTH`, plus an occupancy counter.
- `dispatch_ready_o` = (`DEPTH` − occupancy ≥ 2) && !`flush_i`. Ready uses current occupancy only; a same-cycle pop does not raise it.
- Push fires when `dispatch_valid_i && dispatch_ready_o`.
  - Lanes `0..min(count,2)-1` are written in order: lane 0 at wptr, lane 1 at wptr+1.
  - wptr advances by the lane count.
  - Count 0 is a no-op beat.
- `issue_valid_o` = occupancy ≠ 0 && state == RUN && !`flush_i`.
- `issue_uop_o` and `issue_is_capability_o` show the head entry. When the queue is empty, the head-slot contents are don't-care.
- Pop fires when `issue_valid_o && issue_ready_i`; rptr advances by 1.
- Push and pop in the same cycle: occupancy_next = occupancy + lanes − pop.
- Counter: incremented by 1 on each pop with `issue_is_capability_o` = 1; wraps 0xFFFF→0x0000.
- FSM states RUN and WAIT_CAP (WAIT_CAP exists only with the macro):
  - RUN → WAIT_CAP: on a pop of a capability entry.
  - WAIT_CAP → RUN: on `cap_complete_i` = 1 sampled in WAIT_CAP.
  - `cap_complete_i` is ignored in RUN.
  - Pushes continue normally in WAIT_CAP.
- `flush_i`:
  - Next cycle: pointers = 0, occupancy = 0, state = RUN.
  - Any same-cycle push is dropped (ready is low).
  - Counter unaffected.
  - Flush takes priority over pop; no pop occurs in a flush cycle.
- Reset sets pointers 0, occupancy 0, state RUN, counter 0.
  - Outputs during and after reset: `dispatch_ready_o` = 1 (when `flush_i` = 0), `issue_valid_o` = 0, `occupancy_o` = 0, `capability_issued_count_o` = 0.
  - Storage contents are not reset.
  - Reset mid-operation discards all entries and any pending WAIT_CAP.

## Timing
- An entry pushed at edge N is visible on `issue_valid_o` in cycle N+1; there is no bypass.
- Throughput: 2 in / 1 out per cycle.
- Pop → WAIT_CAP at the next edge. `issue_valid_o` is low in every WAIT_CAP cycle, including the cycle in which `cap_complete_i` is high. It may rise one cycle after `cap_complete_i`.
- `occupancy_o` and `capability_issued_count_o` are registered and update one edge after the causing event.
- `dispatch_ready_o` and `issue_valid_o` are combinational from registered state and `flush_i`. They have no combinational path from `dispatch_valid_i` or `issue_ready_i`.

## Configuration
- `DISPATCH_CAP_SERIALIZE_EN` defined:
  - The WAIT_CAP state exists.
  - After each capability issue, no further issue occurs until `cap_complete_i`.
- `DISPATCH_CAP_SERIALIZE_EN` not defined:
  - The FSM stays in RUN.
  - `cap_complete_i` is unused.
  - Capability entries issue back-to-back like any other entry.
  - The counter still counts them.

## Test plan
- Reset, then push {INT_ALU, CAP_JUMP}, count 2, cap flags 2'b10, with `issue_ready_i` = 1:
  - Next cycle: `issue_uop_o` = INT_ALU.
  - The cycle after: CAP_JUMP with `issue_is_capability_o` = 1.
  - `capability_issued_count_o` = 1; `occupancy_o` returns to 0.
- Fill with `issue_ready_i` = 0:
  - After 3 two-lane beats (occupancy 6, DEPTH 8), `dispatch_ready_o` = 1.
  - After the 4th beat (occupancy 8), `dispatch_ready_o` = 0, and a held valid beat is not written.
- Wrap-around: push and pop 20 single-lane beats with distinct tags; issue order must equal push order across pointer wrap.
- With `DISPATCH_CAP_SERIALIZE_EN`: queue {CAP_RET, INT_ALU}, ready held high.
  - `issue_valid_o` drops after CAP_RET.
  - It stays low until 3 cycles later, when `cap_complete_i` pulses.
  - INT_ALU issues the cycle after the pulse.
  - Without the macro, INT_ALU issues the cycle immediately after CAP_RET.
- `flush_i` with occupancy 5 while in WAIT_CAP, plus a same-cycle valid beat:
  - Next cycle: occupancy 0, state RUN, `issue_valid_o` = 0.
  - The beat is not stored; the counter is unchanged.
- Count value 3 with 2 free slots: exactly 2 entries written, occupancy +2.
- Counter wrap: after 65 536 capability issues, `capability_issued_count_o` reads 0.
